// File: rtl/out_port_unit.sv
// Output-port unit: a small FIFO decouples write-back OUT instructions from a
// slow external device, which consumes OUT_PORT through a valid/ack handshake.
module out_port_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     out_signal,
  input  logic [WIDTH-1:0]         out_data,
  output logic                     stall_out,
  output logic [WIDTH-1:0]         OUT_PORT,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out_port;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign w_push  = out_signal && !w_full;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ack) begin
          if (!w_empty) w_pop        = 1'b1;
          else          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_out_port <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) begin
        r_rptr     <= r_rptr + PTR_ONE;
        r_out_port <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= out_data;
  end

  assign stall_out  = w_full;
  assign OUT_PORT   = r_out_port;
  assign out_valid  = (r_state == S_SEND);
  assign fifo_count = r_count;

endmodule
